// File: rtl/lsm_sequencer.sv
// Load/Store Multiple sequencer: expands one LM/SM into one memory micro-op per set
// register-mask bit, ascending register order, consecutive addresses.
module lsm_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_mask,
    input  logic              flush,
    input  logic              stall_in,
    output logic              busy,
    output logic              stall_fetch,
    output logic              uop_valid,
    output logic              uop_is_load,
    output logic [ADDR_W-1:0] uop_addr,
    output logic [2:0]        uop_reg,
    output logic              uop_last,
    output logic              done
);

    localparam logic [3:0] OpLm = 4'b0110;
    localparam logic [3:0] OpSm = 4'b0111;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [NREG-1:0]     mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                is_load_q, is_load_d;

    logic                accept;
    logic [NREG-1:0]     mask_rest;
    logic                mask_single;
    logic [2:0]          low_idx;

    assign accept = start_valid && (state_q == StIdle) && !flush &&
                    ((opcode == OpLm) || (opcode == OpSm));

    // Clearing the lowest set bit; the remainder being zero means one bit is left.
    assign mask_rest   = mask_q & (mask_q - {{(NREG-1){1'b0}}, 1'b1});
    assign mask_single = (mask_q != '0) && (mask_rest == '0);

    always_comb begin
        low_idx = 3'd0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = i[2:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mask_q    <= '0;
            addr_q    <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            is_load_q <= is_load_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        is_load_d = is_load_q;
        if (flush) begin
            state_d = StIdle;
            mask_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        mask_d    = reg_mask;
                        addr_d    = base_addr;
                        is_load_d = (opcode == OpLm);
                        state_d   = (reg_mask != '0) ? StRun : StDone;
                    end
                end
                StRun: begin
                    if (!stall_in) begin
                        mask_d = mask_rest;
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (mask_single) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    mask_d  = '0;
                end
            endcase
        end
    end

    // Outputs: micro-op fields come from registers only and read zero outside RUN.
    always_comb begin
        start_ready = (state_q == StIdle);
        busy        = (state_q != StIdle);
        stall_fetch = busy || accept;
        uop_valid   = 1'b0;
        uop_is_load = 1'b0;
        uop_addr    = '0;
        uop_reg     = 3'd0;
        uop_last    = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StRun: begin
                uop_valid   = 1'b1;
                uop_is_load = is_load_q;
                uop_addr    = addr_q;
                uop_reg     = low_idx;
                uop_last    = mask_single;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed per-cycle vector bench for lsm_sequencer; each row gives the inputs for one
// cycle and the outputs expected during that same cycle.
module tb_lsm_sequencer;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [3:0]  opcode;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic        flush;
    logic        stall_in;
    logic        busy;
    logic        stall_fetch;
    logic        uop_valid;
    logic        uop_is_load;
    logic [15:0] uop_addr;
    logic [2:0]  uop_reg;
    logic        uop_last;
    logic        done;

    lsm_sequencer #(.ADDR_W(16), .NREG(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .opcode      (opcode),
        .base_addr   (base_addr),
        .reg_mask    (reg_mask),
        .flush       (flush),
        .stall_in    (stall_in),
        .busy        (busy),
        .stall_fetch (stall_fetch),
        .uop_valid   (uop_valid),
        .uop_is_load (uop_is_load),
        .uop_addr    (uop_addr),
        .uop_reg     (uop_reg),
        .uop_last    (uop_last),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, is_load, addr[15:0], reg[2:0], last, done, busy, ready, stall_fetch}
    logic [25:0] obs;
    assign obs = {uop_valid, uop_is_load, uop_addr, uop_reg, uop_last, done, busy,
                  start_ready, stall_fetch};

    typedef struct packed {
        logic        rst;
        logic        sv;
        logic [3:0]  op;
        logic [15:0] base;
        logic [7:0]  mask;
        logic        fl;
        logic        st;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic r, input logic sv, input logic [3:0] op,
                       input logic [15:0] base, input logic [7:0] mask, input logic fl,
                       input logic st, input logic v, input logic ld, input logic [15:0] a,
                       input logic [2:0] rg, input logic last, input logic dn,
                       input logic bsy, input logic rdy, input logic sf);
        vec_t x;
        x.rst  = r;
        x.sv   = sv;
        x.op   = op;
        x.base = base;
        x.mask = mask;
        x.fl   = fl;
        x.st   = st;
        x.exp  = {v, ld, a, rg, last, dn, bsy, rdy, sf};
        vecs.push_back(x);
    endtask

    // Shorthands for common row shapes
    task automatic idle_row();
        add(0, 0, 4'h0, 16'h0, 8'h0, 0, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 1, 0);
    endtask

    task automatic start_row(input logic [3:0] op, input logic [15:0] base,
                             input logic [7:0] mask);
        add(0, 1, op, base, mask, 0, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 1, 1);
    endtask

    task automatic uop_row(input logic st, input logic ld, input logic [15:0] a,
                           input logic [2:0] rg, input logic last);
        add(0, 0, 4'h0, 16'h0, 8'h0, 0, st, 1, ld, a, rg, last, 0, 1, 0, 1);
    endtask

    task automatic done_row();
        add(0, 0, 4'h0, 16'h0, 8'h0, 0, 0, 0, 0, 16'h0, 3'd0, 0, 1, 1, 0, 1);
    endtask

    task automatic run_row(input vec_t x, input string nm);
        @(negedge clk);
        rst         = x.rst;
        start_valid = x.sv;
        opcode      = x.op;
        base_addr   = x.base;
        reg_mask    = x.mask;
        flush       = x.fl;
        stall_in    = x.st;
        #2;
        checks++;
        if (obs !== x.exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (v,ld,addr,reg,last,done,busy,rdy,sf)",
                     nm, obs, x.exp);
        end
    endtask

    initial begin
        rst = 1'b1; start_valid = 1'b0; opcode = 4'h0; base_addr = 16'h0;
        reg_mask = 8'h0; flush = 1'b0; stall_in = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state
        idle_row();
        // LM 0x0B @ 0x0100
        start_row(4'b0110, 16'h0100, 8'h0B);
        uop_row(0, 1, 16'h0100, 3'd0, 0);
        uop_row(0, 1, 16'h0101, 3'd1, 0);
        uop_row(0, 1, 16'h0102, 3'd3, 1);
        done_row();
        idle_row();
        // LM empty mask
        start_row(4'b0110, 16'h1234, 8'h00);
        done_row();
        idle_row();
        // SM 0x81 @ 0xFFFF, address wraps
        start_row(4'b0111, 16'hFFFF, 8'h81);
        uop_row(0, 0, 16'hFFFF, 3'd0, 0);
        uop_row(0, 0, 16'h0000, 3'd7, 1);
        done_row();
        idle_row();
        // LM 0xF0, flush at N+2, then a new SM start at N+3
        start_row(4'b0110, 16'h0300, 8'hF0);
        uop_row(0, 1, 16'h0300, 3'd4, 0);
        add(0, 0, 4'h0, 16'h0, 8'h0, 1, 0, 1, 1, 16'h0301, 3'd5, 0, 0, 1, 0, 1);
        start_row(4'b0111, 16'h0040, 8'h01);
        uop_row(0, 0, 16'h0040, 3'd0, 1);
        done_row();
        idle_row();
        // Flush alongside a start in IDLE: not accepted
        add(0, 1, 4'b0110, 16'h0500, 8'h0F, 1, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 1, 0);
        idle_row();
        // Non-LM/SM opcode ignored
        add(0, 1, 4'b0100, 16'h0600, 8'hFF, 0, 0, 0, 0, 16'h0, 3'd0, 0, 0, 0, 1, 0);
        idle_row();
        // Second start during RUN ignored
        start_row(4'b0110, 16'h0010, 8'h06);
        add(0, 1, 4'b0111, 16'h5555, 8'hFF, 0, 0, 1, 1, 16'h0010, 3'd1, 0, 0, 1, 0, 1);
        uop_row(0, 1, 16'h0011, 3'd2, 1);
        done_row();
        idle_row();
        // rst at N+2 of an 8-bit sequence
        start_row(4'b0110, 16'h0A00, 8'hFF);
        uop_row(0, 1, 16'h0A00, 3'd0, 0);
        add(1, 0, 4'h0, 16'h0, 8'h0, 0, 0, 1, 1, 16'h0A01, 3'd1, 0, 0, 1, 0, 1);
        idle_row();
        idle_row();

        foreach (vecs[i]) run_row(vecs[i], $sformatf("vec%0d", i));

        // SM 0xFF @ 0x2000 with stall_in at N+2 and N+3: R1 held for three cycles
        vecs.delete();
        start_row(4'b0111, 16'h2000, 8'hFF);
        uop_row(0, 0, 16'h2000, 3'd0, 0);
        uop_row(1, 0, 16'h2001, 3'd1, 0);
        uop_row(1, 0, 16'h2001, 3'd1, 0);
        uop_row(0, 0, 16'h2001, 3'd1, 0);
        for (int k = 2; k < 8; k++) begin
            uop_row(0, 0, 16'h2000 + 16'(k), 3'(k), (k == 7));
        end
        done_row();
        idle_row();
        foreach (vecs[i]) run_row(vecs[i], $sformatf("stall%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Micro-op sequencer for the Load Multiple (LM, opcode 4'b0110) and Store Multiple (SM, opcode 4'b0111) instructions.
- Sits between register-read and the execute stage.
- Expands one LM/SM into one single-register memory micro-op per set bit of an 8-bit register mask, using consecutive addresses.
- Holds fetch/decode frozen while the expansion runs.

Parameters:
ADDR_W, 16, width of base address and micro-op address
NREG, 8, number of architectural registers (mask width); index width is 3

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_valid  in  1  LM/SM instruction presented by register-read
start_ready  out  1  combinational; high when state is IDLE
opcode  in  4  instruction opcode; only 4'b0110 and 4'b0111 start a sequence
base_addr  in  ADDR_W  effective base address (rb + sign-extended imm6)
reg_mask  in  NREG  bit i set means register Ri participates
flush  in  1  branch-mispredict flush; aborts the sequence
stall_in  in  1  execute stage frozen; current micro-op is not consumed
busy  out  1  state is not IDLE
stall_fetch  out  1  busy OR start accepted this cycle; freezes earlier stages
uop_valid  out  1  micro-op present for execute
uop_is_load  out  1  1 = LM (mem_r), 0 = SM (mem_w)
uop_addr  out  ADDR_W  memory address of the current micro-op
uop_reg  out  3  register index to load into or store from
uop_last  out  1  current micro-op is the final one
done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset behaviour (rst, synchronous, highest priority):
  - state = IDLE; pending mask = 0; address register = 0; op register = 0.
  - Outputs: uop_valid = 0, uop_is_load = 0, uop_addr = 0, uop_reg = 0, uop_last = 0, done = 0, busy = 0, stall_fetch = 0.
  - rst mid-sequence discards all remaining micro-ops; no done pulse.
- States: IDLE, RUN, DONE.
- Accept condition: start_valid && state==IDLE && !flush && opcode in {0110, 0111}.
  - Any other opcode is ignored: no state change, start_ready stays 1.
- On accept (cycle N), latch the inputs:
  - pending mask <= reg_mask
  - address register <= base_addr
  - op register <= (opcode==0110)
- Transition on accept:
  - reg_mask != 0: go to RUN.
  - reg_mask == 0: go to DONE. No micro-op is issued; done = 1 in cycle N+1.
- RUN state outputs (all decoded from registers only, no input-to-output combinational path):
  - uop_valid = 1.
  - uop_reg = index of the lowest set bit of the pending mask.
  - uop_addr = address register.
  - uop_is_load = op register.
  - uop_last = 1 when the pending mask has exactly one bit set.
- In RUN with stall_in = 0, the micro-op is consumed:
  - Clear the lowest set bit of the pending mask.
  - Address register increments by 1, modulo 2^ADDR_W (0xFFFF+1 = 0x0000).
  - If the consumed micro-op had uop_last = 1, go to DONE.
- In RUN with stall_in = 1: hold all state; outputs remain stable and uop_valid stays 1.
- Issue order is ascending register index: R0 first, R7 last.
- Latency: first micro-op appears at N+1. With no stalls, k set bits give micro-ops at N+1..N+k and done at N+k+1.
- DONE state:
  - done = 1 and uop_valid = 0 for exactly one cycle, then go to IDLE unconditionally.
  - busy = 1 in DONE; start_ready = 0.
- Flush (priority below rst, above everything else):
  - In any state, the next state is IDLE; pending mask is cleared; uop_valid = 0 from the next cycle.
  - No done pulse for a flushed sequence.
  - flush with start_valid in IDLE: the start is not accepted.
- start_valid while busy is ignored. Register-read holds the instruction because stall_fetch is high.
- Widths: address arithmetic is ADDR_W bits, unsigned, and the carry is dropped. uop_reg is the 3-bit encoding of the bit index.
- Downstream mapping:
  - uop_valid && uop_is_load drives the execute-stage mem_r plus writeback.
  - uop_valid && !uop_is_load drives mem_w, with store_data taken from register uop_reg.

Test Plan:
- LM, reg_mask = 8'b0000_1011, base = 0x0100, no stall -> micro-ops (R0, 0x0100), (R1, 0x0101), (R3, 0x0102) at N+1..N+3, uop_is_load = 1, uop_last only at N+3, done at N+4, start_ready = 1 at N+5.
- SM, mask = 8'hFF, base = 0x2000, stall_in high at N+2 and N+3 -> R1 at 0x2001 held stable for 3 cycles, R7 at 0x2007, done at N+11, uop_is_load = 0 throughout.
- LM, mask = 0x00 -> uop_valid never rises, done at N+1, IDLE at N+2, busy = 1 only at N+1.
- SM, mask = 8'h81, base = 0xFFFF -> R0 at 0xFFFF, then R7 at 0x0000 (wrap), done after R7.
- LM, mask = 8'hF0, flush at N+2 -> R4 issued at N+1, R5 visible at N+2, uop_valid = 0 from N+3, no done, IDLE at N+3; a new start at N+3 is accepted.
- Second start_valid during RUN, and start_valid with opcode 4'b0100 in IDLE -> both ignored, mask unchanged, no micro-ops; rst asserted at N+2 of an 8-bit sequence -> all outputs 0 at N+3.
